uart_echo_checker: RTL and testbench
====================================

Name: uart_echo_checker

Overview:
Host-side initiator for the UART echo path: the other end of a loopback responder. It drives the byte interface of uart_tool_tx with a generated pattern and consumes the byte interface of uart_tool_rx. Each returned byte is compared against the byte sent, with timeouts on missing echoes, and pass/fail plus error counters are reported. It sits in a link-test top next to uart_tool_tx and uart_tool_rx, facing a board running the echo design.

Parameters:
NUM_BYTES, 16, bytes sent per run (1..65535)
TIMEOUT_CYCLES, 60000, clk cycles to wait for each echo (about 2 frames at 25 MHz / 9600 baud)
LFSR_SEED, 8'h01, initial LFSR value (must be nonzero)
INC_START, 8'h00, first byte in incrementing mode

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin a run
mode  in  1  0 = incrementing pattern, 1 = LFSR pattern; sampled on start
uart_tx_en  out  1  one-cycle request to uart_tool_tx
uart_tx_data  out  8  byte to transmit
uart_tx_busy  in  1  transmitter busy
uart_rx_valid  in  1  one-cycle received-byte strobe
uart_rx_data  in  8  received byte
uart_rx_break  in  1  BREAK detected
running  out  1  run in progress
done  out  1  high from end of run until next start
pass  out  1  valid when done: 1 iff err_count == 0 and timeout_count == 0
err_count  out  16  mismatches, BREAKs and spurious bytes; saturates at 16'hFFFF
timeout_count  out  16  echoes not received in time; saturates
last_rx_data  out  8  most recent received byte

Behaviour:
- Reset (async, resetn=0): state IDLE; uart_tx_en=0, uart_tx_data=0, running=0, done=0, pass=0, both counters=0, last_rx_data=0, byte index=0, timer=0.
- States: IDLE, SEND, WAIT_ECHO, NEXT, DONE.
- IDLE/DONE + start:
  - Clear both counters, done and pass.
  - Latch mode. Load pattern register with INC_START (mode 0) or LFSR_SEED (mode 1). Index = 0.
  - Go to SEND; running=1 from the next cycle.
- start while running: ignored.
- SEND:
  - Wait until uart_tx_busy==0.
  - Then assert uart_tx_en for exactly 1 cycle, with uart_tx_data = pattern held stable from that cycle until the next SEND.
  - Clear timer and go to WAIT_ECHO.
- WAIT_ECHO: timer increments every cycle. Priority order:
  - uart_rx_valid: last_rx_data <= uart_rx_data. If the data differs from the pattern, err_count += 1. Go to NEXT.
  - Else uart_rx_break: err_count += 1; go to NEXT.
  - Else timer == TIMEOUT_CYCLES-1: timeout_count += 1; go to NEXT.
- NEXT (1 cycle):
  - Advance the pattern. Incrementing: +1 mod 256. LFSR: next = {p[6:0], p[7]^p[5]^p[4]^p[3]}.
  - Index += 1. If index == NUM_BYTES-1 before the increment, go to DONE, else go to SEND.
- DONE: running=0, done=1, pass = (err_count==0 && timeout_count==0). Outputs hold until start or reset.
- Spurious input (uart_rx_valid or uart_rx_break outside WAIT_ECHO while running): err_count += 1. In IDLE/DONE these are ignored, but last_rx_data still updates on uart_rx_valid.
- A late echo arriving after its timeout lands in SEND or NEXT and counts as spurious.
- Counters saturate and never wrap.
- Latency: rx_valid to counter update is 1 cycle. The last echo to done=1 is 2 cycles (NEXT, then DONE registered).
- Reset mid-run: immediate return to reset values; no uart_tx_en glitch.

Test Plan:
- Ideal loopback model (uart_tx_en -> busy for 20 cycles -> rx_valid with the same byte 30 cycles later), mode 0, NUM_BYTES=16 -> tx bytes 00..0F in order, done=1, pass=1, err_count=0, timeout_count=0, last_rx_data=0F.
- Mode 1, NUM_BYTES=8 -> tx sequence 01 02 04 08 11 23 47 8E; pass=1.
- Model corrupts the 6th echo (returns 0x55 instead of 0x05), mode 0 -> err_count=1, timeout_count=0, pass=0, exactly 16 uart_tx_en pulses.
- No echo, NUM_BYTES=4, TIMEOUT_CYCLES=100 -> timeout_count=4, err_count=0, pass=0. Each uart_tx_en is spaced at least 100 cycles apart.
- uart_rx_break during the 2nd wait, plus an extra rx_valid in the same run while in SEND -> err_count=2. Extra rx_valid in IDLE -> counters unchanged.
- resetn low while in WAIT_ECHO of byte 3 -> all outputs at reset values in that cycle. A following start reruns from INC_START with counters at 0. A start pulse while running causes no restart.

Source files
------------

// File: rtl/uart_echo_checker.sv
// Host-side UART echo initiator: sends an incrementing or LFSR byte pattern,
// checks each echoed byte with a per-byte timeout and reports error counters.
module uart_echo_checker #(
    parameter int          NUM_BYTES      = 16,
    parameter int          TIMEOUT_CYCLES = 60000,
    parameter logic [7:0]  LFSR_SEED      = 8'h01,
    parameter logic [7:0]  INC_START      = 8'h00
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        mode,
    output logic        uart_tx_en,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_tx_busy,
    input  logic        uart_rx_valid,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_break,
    output logic        running,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] timeout_count,
    output logic [7:0]  last_rx_data
);

    localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  T_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]    IDX_LAST = 16'(NUM_BYTES - 1);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_ECHO, NEXT, DONE} state_t;

    state_t        state, state_nxt;
    logic          mode_q;
    logic [7:0]    pattern;
    logic [15:0]   idx;
    logic [TW-1:0] timer;
    logic          err_inc, to_inc, launch, begin_run;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        state_nxt = state;
        err_inc   = 1'b0;
        to_inc    = 1'b0;
        launch    = 1'b0;
        begin_run = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    begin_run = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                // anything arriving outside the echo window is spurious
                err_inc = uart_rx_valid | uart_rx_break;
                if (!uart_tx_busy) begin
                    launch    = 1'b1;
                    state_nxt = WAIT_ECHO;
                end
            end
            WAIT_ECHO: begin
                if (uart_rx_valid) begin
                    err_inc   = (uart_rx_data != pattern);
                    state_nxt = NEXT;
                end else if (uart_rx_break) begin
                    err_inc   = 1'b1;
                    state_nxt = NEXT;
                end else if (timer == T_LAST) begin
                    to_inc    = 1'b1;
                    state_nxt = NEXT;
                end
            end
            NEXT: begin
                err_inc   = uart_rx_valid | uart_rx_break;
                state_nxt = (idx == IDX_LAST) ? DONE : SEND;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            mode_q        <= 1'b0;
            pattern       <= 8'h00;
            idx           <= 16'd0;
            timer         <= '0;
            uart_tx_en    <= 1'b0;
            uart_tx_data  <= 8'h00;
            err_count     <= 16'd0;
            timeout_count <= 16'd0;
            last_rx_data  <= 8'h00;
        end else begin
            state      <= state_nxt;
            uart_tx_en <= launch;
            if (launch)
                uart_tx_data <= pattern;
            if (uart_rx_valid)
                last_rx_data <= uart_rx_data;

            if (begin_run) begin
                err_count     <= 16'd0;
                timeout_count <= 16'd0;
                mode_q        <= mode;
                pattern       <= mode ? LFSR_SEED : INC_START;
                idx           <= 16'd0;
            end else begin
                if (err_inc) err_count     <= sat_inc(err_count);
                if (to_inc)  timeout_count <= sat_inc(timeout_count);
            end

            if (launch)
                timer <= '0;
            else if (state == WAIT_ECHO)
                timer <= timer + 1'b1;

            if (state == NEXT) begin
                pattern <= mode_q ? {pattern[6:0], pattern[7] ^ pattern[5] ^ pattern[4] ^ pattern[3]}
                                  : pattern + 8'd1;
                idx     <= idx + 16'd1;
            end
        end
    end

    assign running = (state == SEND) || (state == WAIT_ECHO) || (state == NEXT);
    assign done    = (state == DONE);
    assign pass    = done && (err_count == 16'd0) && (timeout_count == 16'd0);

endmodule

// File: tb/tb_uart_echo_checker.sv
// Bench for uart_echo_checker: loopback model on the UART byte interface and
// a scoreboard of expected transmit bytes popped on every uart_tx_en.
module tb_uart_echo_checker;

    localparam int NB = 8;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        uart_tx_busy = 1'b0;
    logic        uart_rx_valid = 1'b0;
    logic [7:0]  uart_rx_data = 8'h00;
    logic        uart_rx_break = 1'b0;
    logic        uart_tx_en;
    logic [7:0]  uart_tx_data;
    logic        running, done, pass;
    logic [15:0] err_count, timeout_count;
    logic [7:0]  last_rx_data;

    uart_echo_checker #(
        .NUM_BYTES(NB), .TIMEOUT_CYCLES(TO), .LFSR_SEED(8'h01), .INC_START(8'h00)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .mode(mode),
        .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data), .uart_tx_busy(uart_tx_busy),
        .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data), .uart_rx_break(uart_rx_break),
        .running(running), .done(done), .pass(pass),
        .err_count(err_count), .timeout_count(timeout_count), .last_rx_data(last_rx_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int ntx_run = 0;
    logic [7:0] exp_q[$];

    // model configuration, written only by the test sequence
    bit echo_en     = 1'b1;
    bit spacing_chk = 1'b0;
    int corrupt_idx = -1;
    int brk_idx     = -1;
    int inj_seq     = 0;

    // loopback model: busy for 20 cycles, echo 30 cycles after uart_tx_en
    int busy_cnt = 0, echo_cnt = 0, brk_cnt = 0, spur_cnt = 0, m_idx = 0, inj_seen = 0;
    logic [7:0] echo_byte = 8'h00;

    always @(negedge clk) begin
        uart_rx_valid = 1'b0;
        uart_rx_break = 1'b0;
        if (!resetn) begin
            busy_cnt = 0; echo_cnt = 0; brk_cnt = 0; spur_cnt = 0; m_idx = 0;
            uart_tx_busy = 1'b0;
        end else begin
            if (!running) m_idx = 0;
            if (busy_cnt > 0) begin busy_cnt--; if (busy_cnt == 0) uart_tx_busy = 1'b0; end
            if (echo_cnt > 0) begin
                echo_cnt--;
                if (echo_cnt == 0) begin uart_rx_valid = 1'b1; uart_rx_data = echo_byte; end
            end
            if (brk_cnt > 0) begin brk_cnt--; if (brk_cnt == 0) uart_rx_break = 1'b1; end
            if (spur_cnt > 0) begin
                spur_cnt--;
                if (spur_cnt == 0) begin uart_rx_valid = 1'b1; uart_rx_data = 8'hAA; end
            end
            if (inj_seq != inj_seen) begin
                inj_seen = inj_seq;
                uart_rx_valid = 1'b1;
                uart_rx_data  = 8'hC3;
            end
            if (uart_tx_en === 1'b1) begin
                uart_tx_busy = 1'b1;
                busy_cnt = 20;
                if (m_idx == brk_idx) begin
                    brk_cnt  = 10;
                    spur_cnt = 15;
                end else if (echo_en) begin
                    echo_cnt  = 30;
                    echo_byte = (m_idx == corrupt_idx) ? 8'h55 : uart_tx_data;
                end
                m_idx++;
            end
        end
    end

    task automatic start_run(input logic m);
        logic [7:0] lfsr_tab [8];
        lfsr_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
        for (int i = 0; i < NB; i++)
            exp_q.push_back(m ? lfsr_tab[i] : 8'(i));
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // stop_at == 0: wait for done; otherwise stop after stop_at transmits
    task automatic run_wait(input int budget, input int stop_at);
        int n, last;
        bit reached;
        logic [7:0] e;
        n = 0; last = -1000; ntx_run = 0; reached = 1'b0;
        while (n < budget && !reached) begin
            @(negedge clk);
            n++;
            if (uart_tx_en === 1'b1) begin
                ntx_run++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_extra: got %h want no transmit", uart_tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (uart_tx_data !== e) begin
                        errors++;
                        $display("FAIL tx_data: got %h want %h", uart_tx_data, e);
                    end
                end
                if (spacing_chk) begin
                    checks++;
                    if (n - last < TO) begin
                        errors++;
                        $display("FAIL tx_spacing: got %0d want >= %0d", n - last, TO);
                    end
                end
                last = n;
            end
            reached = (stop_at == 0) ? (done === 1'b1) : (ntx_run >= stop_at);
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL run_wait: budget %0d cycles expired, got %0d transmits", budget, ntx_run);
        end
    endtask

    task automatic check_end(input string name, input logic p, input logic [15:0] e_err,
                             input logic [15:0] e_to, input logic [7:0] e_last);
        checks++;
        if ({done, pass} !== {1'b1, p}) begin
            errors++;
            $display("FAIL %s done/pass: got %b%b want 1%b", name, done, pass, p);
        end
        checks++;
        if (err_count !== e_err) begin
            errors++;
            $display("FAIL %s err_count: got %0d want %0d", name, err_count, e_err);
        end
        checks++;
        if (timeout_count !== e_to) begin
            errors++;
            $display("FAIL %s timeout_count: got %0d want %0d", name, timeout_count, e_to);
        end
        checks++;
        if (last_rx_data !== e_last) begin
            errors++;
            $display("FAIL %s last_rx_data: got %h want %h", name, last_rx_data, e_last);
        end
        checks++;
        if (ntx_run !== NB || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s tx_count: got %0d (left %0d) want %0d", name, ntx_run, exp_q.size(), NB);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({uart_tx_en, uart_tx_data, running, done, pass, err_count, timeout_count, last_rx_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b d=%h run=%b done=%b pass=%b err=%0d to=%0d last=%h want all 0",
                     uart_tx_en, uart_tx_data, running, done, pass, err_count, timeout_count, last_rx_data);
        end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({running, done, uart_tx_en} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: got run=%b done=%b en=%b want 000", running, done, uart_tx_en);
        end
    endtask

    task automatic test_incrementing();
        start_run(1'b0);
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL inc_running: got %b want 1", running);
        end
        run_wait(2000, 0);
        check_end("inc", 1'b1, 16'd0, 16'd0, 8'h07);
    endtask

    task automatic test_lfsr();
        start_run(1'b1);
        run_wait(2000, 0);
        check_end("lfsr", 1'b1, 16'd0, 16'd0, 8'h8E);
    endtask

    task automatic test_corrupt();
        corrupt_idx = 5;
        start_run(1'b0);
        run_wait(2000, 0);
        check_end("corrupt", 1'b0, 16'd1, 16'd0, 8'h07);
        corrupt_idx = -1;
    endtask

    task automatic test_timeout();
        echo_en = 1'b0;
        spacing_chk = 1'b1;
        start_run(1'b0);
        run_wait(3000, 0);
        check_end("timeout", 1'b0, 16'd0, 16'(NB), 8'h07);
        echo_en = 1'b1;
        spacing_chk = 1'b0;
    endtask

    task automatic test_break_spurious();
        brk_idx = 1;
        start_run(1'b0);
        run_wait(2000, 0);
        check_end("break", 1'b0, 16'd2, 16'd0, 8'h07);
        brk_idx = -1;
        inj_seq++;
        repeat (3) @(negedge clk);
        checks++;
        if ({done, err_count, timeout_count, last_rx_data} !== {1'b1, 16'd2, 16'd0, 8'hC3}) begin
            errors++;
            $display("FAIL idle_rx: got done=%b err=%0d to=%0d last=%h want 1 2 0 c3",
                     done, err_count, timeout_count, last_rx_data);
        end
    endtask

    task automatic test_reset_mid_run();
        start_run(1'b0);
        run_wait(1000, 3);
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++;
        if ({uart_tx_en, uart_tx_data, running, done, pass, err_count, timeout_count, last_rx_data} !== '0) begin
            errors++;
            $display("FAIL midrun_reset: got en=%b d=%h run=%b done=%b pass=%b err=%0d to=%0d last=%h want all 0",
                     uart_tx_en, uart_tx_data, running, done, pass, err_count, timeout_count, last_rx_data);
        end
        @(negedge clk);
        resetn = 1'b1;
        exp_q.delete();
        start_run(1'b0);
        checks++;
        if ({running, err_count, timeout_count} !== {1'b1, 16'd0, 16'd0}) begin
            errors++;
            $display("FAIL rerun_start: got run=%b err=%0d to=%0d want 1 0 0", running, err_count, timeout_count);
        end
        run_wait(1000, 3);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_wait(2000, 0);
        checks++;
        if ({pass, err_count, timeout_count, last_rx_data} !== {1'b1, 16'd0, 16'd0, 8'h07}
            || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rerun_end: got pass=%b err=%0d to=%0d last=%h left=%0d want 1 0 0 07 0",
                     pass, err_count, timeout_count, last_rx_data, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_incrementing();
        test_lfsr();
        test_corrupt();
        test_timeout();
        test_break_spurious();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
